awb_gain_calc: RTL

AWB_GAIN_CALC -- requirements
Module: awb_gain_calc

---
 rtl/awb_gain_calc.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/awb_gain_calc.sv
// Auto-white-balance gain calculator: accumulates per-channel frame sums and derives
// R/B gains relative to green with a single shared serial restoring divider.
module awb_gain_calc #(
    parameter logic [19:0] P_GAIN_MAX   = 20'h04000,
    parameter logic [19:0] P_GAIN_UNITY = 20'h01000
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_rgb888_frame_start,
    input  logic        I_rgb888_frame_end,
    input  logic        I_rgb888_valid,
    input  logic [95:0] I_rgb888_data,
    input  logic        I_awb_en,
    output logic [19:0] O_r_gain,
    output logic [19:0] O_g_gain,
    output logic [19:0] O_b_gain,
    output logic        O_gain_update,
    output logic        O_busy
);

    typedef enum logic [1:0] {S_IDLE, S_DIV_R, S_DIV_B, S_UPDATE} state_t;

    // Channel index 0 = R, 1 = G, 2 = B
    logic [2:0][31:0] sum_next;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_ch
            logic [9:0]  beat_sum;
            logic [32:0] acc_wide;
            logic [31:0] acc_reg;
            logic [31:0] acc_next;

            always_comb begin
                beat_sum = '0;
                for (int p = 0; p < 4; p++) begin
                    beat_sum = beat_sum + {2'b00, I_rgb888_data[p*24 + (2-gi)*8 +: 8]};
                end
                acc_wide = {1'b0, acc_reg} + {23'd0, beat_sum};
                if (I_rgb888_frame_start) begin
                    acc_next = I_rgb888_valid ? {22'd0, beat_sum} : 32'd0;
                end else if (I_rgb888_valid) begin
                    acc_next = acc_wide[32] ? 32'hFFFF_FFFF : acc_wide[31:0];
                end else begin
                    acc_next = acc_reg;
                end
            end

            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end

            assign sum_next[gi] = acc_next;
        end
    endgenerate

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic [31:0] snap_g_reg;
    logic [31:0] snap_b_reg;
    logic [31:0] den_reg;
    logic [31:0] rem_reg;
    logic [43:0] quo_reg;
    logic [19:0] r_quot_reg;
    logic [19:0] b_quot_reg;
    logic [19:0] r_gain_reg;
    logic [19:0] b_gain_reg;
    logic        gain_update_reg;

    // One restoring-division step: quotient bits shift in as dividend bits shift out
    logic [32:0] rem_shift;
    logic [31:0] rem_step;
    logic [43:0] quo_step;

    always_comb begin
        rem_shift = {rem_reg, quo_reg[43]};
        if (rem_shift >= {1'b0, den_reg}) begin
            rem_step = 32'(rem_shift - {1'b0, den_reg});
            quo_step = {quo_reg[42:0], 1'b1};
        end else begin
            rem_step = rem_shift[31:0];
            quo_step = {quo_reg[42:0], 1'b0};
        end
    end

    function automatic logic [19:0] clamp_gain(input logic [43:0] q, input logic [31:0] d);
        logic [19:0] res;
        if (d == 32'd0 || q > {24'd0, P_GAIN_MAX}) begin
            res = P_GAIN_MAX;
        end else begin
            res = q[19:0];
        end
        return res;
    endfunction

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            snap_g_reg      <= '0;
            snap_b_reg      <= '0;
            den_reg         <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            r_quot_reg      <= P_GAIN_UNITY;
            b_quot_reg      <= P_GAIN_UNITY;
            r_gain_reg      <= P_GAIN_UNITY;
            b_gain_reg      <= P_GAIN_UNITY;
            gain_update_reg <= 1'b0;
        end else begin
            gain_update_reg <= 1'b0;
            if (!I_awb_en) begin
                state_reg  <= S_IDLE;
                cnt_reg    <= '0;
                r_gain_reg <= P_GAIN_UNITY;
                b_gain_reg <= P_GAIN_UNITY;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (I_rgb888_frame_end) begin
                            snap_g_reg <= sum_next[1];
                            snap_b_reg <= sum_next[2];
                            den_reg    <= sum_next[0];
                            quo_reg    <= {sum_next[1], 12'd0};
                            rem_reg    <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= S_DIV_R;
                        end
                    end
                    S_DIV_R: begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'd43) begin
                            // Capture R result and reload the divider for the B channel
                            r_quot_reg <= clamp_gain(quo_step, den_reg);
                            den_reg    <= snap_b_reg;
                            quo_reg    <= {snap_g_reg, 12'd0};
                            rem_reg    <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= S_DIV_B;
                        end
                    end
                    S_DIV_B: begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'd43) begin
                            b_quot_reg <= clamp_gain(quo_step, den_reg);
                            cnt_reg    <= '0;
                            state_reg  <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        r_gain_reg      <= r_quot_reg;
                        b_gain_reg      <= b_quot_reg;
                        gain_update_reg <= 1'b1;
                        state_reg       <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign O_r_gain      = r_gain_reg;
    assign O_g_gain      = P_GAIN_UNITY;
    assign O_b_gain      = b_gain_reg;
    assign O_gain_update = gain_update_reg;
    assign O_busy        = (state_reg != S_IDLE);

endmodule
